// File: rtl/core_alu_arbiter_if.sv
// Bundles the two requester channels, the core_alu side-band and the response slot
// shared between the arbiter and its surrounding pipeline logic.
interface core_alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 10
);
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;

  // Arbiter view
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_res, rsp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_data
  );

  // Requester / ALU / consumer view
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_res, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/core_alu_arbiter.sv
// Round-robin sharing of one combinational core_alu between two requesters, with the
// result captured into a single-entry response slot tagged by requester ID.
module core_alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 10
) (
  input logic i_clk,
  input logic i_rst_n,
  core_alu_arbiter_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            r_state;
  logic              r_rspId;
  logic [DATA_W-1:0] r_rspData;
  logic              r_lastGnt;

  logic              w_slotFree;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_grant;

  // On a tie the port that did not win last time is served; reset holds both READYs low.
  assign w_slotFree = (r_state == EMPTY) | bus.rsp_ready;
  assign w_gnt0     = i_rst_n & w_slotFree & bus.req0_valid & (~bus.req1_valid | r_lastGnt);
  assign w_gnt1     = i_rst_n & w_slotFree & bus.req1_valid & (~bus.req0_valid | ~r_lastGnt);
  assign w_grant    = w_gnt0 | w_gnt1;

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;

  assign bus.alu_op = w_gnt0 ? bus.req0_op : (w_gnt1 ? bus.req1_op : '0);
  assign bus.alu_a  = w_gnt0 ? bus.req0_a  : (w_gnt1 ? bus.req1_a  : '0);
  assign bus.alu_b  = w_gnt0 ? bus.req0_b  : (w_gnt1 ? bus.req1_b  : '0);

  assign bus.rsp_valid = (r_state == FULL);
  assign bus.rsp_id    = r_rspId;
  assign bus.rsp_data  = r_rspData;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= EMPTY;
      r_rspId   <= 1'b0;
      r_rspData <= '0;
      r_lastGnt <= 1'b1;
    end else begin
      if (w_grant) begin
        r_rspData <= bus.alu_res;
        r_rspId   <= w_gnt1;
        r_lastGnt <= w_gnt1;
      end
      case (r_state)
        EMPTY:   if (w_grant) r_state <= FULL;
        FULL:    if (!w_grant && bus.rsp_ready) r_state <= EMPTY;
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_core_alu_arbiter.sv
// Scoreboard bench for core_alu_arbiter: per-port drivers issue operations, a monitor
// pops expected results per requester as responses are consumed.
module tb_core_alu_arbiter;

  localparam int DATA_W = 32;
  localparam int OP_W   = 10;

  localparam logic [OP_W-1:0] OP_SUM = 10'h001;
  localparam logic [OP_W-1:0] OP_SUB = 10'h002;
  localparam logic [OP_W-1:0] OP_AND = 10'h004;
  localparam logic [OP_W-1:0] OP_OR  = 10'h008;
  localparam logic [OP_W-1:0] OP_XOR = 10'h010;
  localparam logic [OP_W-1:0] OP_BAD = 10'h3FF;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } reqT;

  logic clk = 1'b0;
  logic rstN;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  reqT               stimQ0[$];
  reqT               stimQ1[$];
  logic [DATA_W-1:0] expQ0[$];
  logic [DATA_W-1:0] expQ1[$];
  logic              gotIds[$];
  int                gotCyc[$];

  core_alu_arbiter_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  core_alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] aluRef(input logic [OP_W-1:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (op)
      OP_SUM:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  assign bus.alu_res = aluRef(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int p, input logic [OP_W-1:0] op,
                               input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    reqT it;
    it.op = op;
    it.a  = a;
    it.b  = b;
    if (p == 0) stimQ0.push_back(it);
    else        stimQ1.push_back(it);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Each requester holds VALID until it sees READY, then presents its next queued op.
  task automatic drivePort(input int p);
    reqT it;
    bit  seen;
    bit  busy;
    seen = 1'b0;
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (seen) begin
        busy = 1'b0;
        if (p == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
      end
      if (!busy && ((p == 0) ? stimQ0.size() : stimQ1.size()) > 0) begin
        it   = (p == 0) ? stimQ0.pop_front() : stimQ1.pop_front();
        busy = 1'b1;
        if (p == 0) begin
          bus.req0_op = it.op; bus.req0_a = it.a; bus.req0_b = it.b; bus.req0_valid = 1'b1;
          expQ0.push_back(aluRef(it.op, it.a, it.b));
        end else begin
          bus.req1_op = it.op; bus.req1_a = it.a; bus.req1_b = it.b; bus.req1_valid = 1'b1;
          expQ1.push_back(aluRef(it.op, it.a, it.b));
        end
      end
      #3;
      seen = rstN && ((p == 0) ? bus.req0_ready : bus.req1_ready);
    end
  endtask

  initial drivePort(0);
  initial drivePort(1);

  // Monitor: every consumed response is matched against its requester's expected FIFO.
  initial begin
    logic [DATA_W-1:0] exp;
    forever begin
      @(negedge clk);
      cyc++;
      #3;
      if (rstN) begin
        checkOutput("ready_onehot", {31'b0, bus.req0_ready & bus.req1_ready}, '0);
        if (bus.rsp_valid && bus.rsp_ready) begin
          if ((bus.rsp_id ? expQ1.size() : expQ0.size()) == 0) begin
            checkOutput("unexpected_rsp", {31'b0, bus.rsp_id}, 32'hDEAD_BEEF);
          end else begin
            exp = bus.rsp_id ? expQ1.pop_front() : expQ0.pop_front();
            checkOutput(bus.rsp_id ? "rsp_data_p1" : "rsp_data_p0", bus.rsp_data, exp);
          end
          gotIds.push_back(bus.rsp_id);
          gotCyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int waited;
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b0;
    rstN = 1'b0;
    repeat (3) tick();

    // Reset holds everything quiet even with a request pending
    applyStimulus(0, OP_SUM, 32'd5, 32'd7);
    tick(); #1;
    checkOutput("rst_req0_ready", {31'b0, bus.req0_ready}, '0);
    checkOutput("rst_rsp_valid", {31'b0, bus.rsp_valid}, '0);
    checkOutput("rst_rsp_data", bus.rsp_data, '0);
    checkOutput("rst_alu_op", {22'b0, bus.alu_op}, '0);

    // Single op, accepted in the release cycle, response one cycle later
    tick();
    rstN = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput("single_ready0", {31'b0, bus.req0_ready}, 32'd1);
    checkOutput("single_alu_op", {22'b0, bus.alu_op}, {22'b0, OP_SUM});
    checkOutput("single_alu_a", bus.alu_a, 32'd5);
    checkOutput("single_alu_b", bus.alu_b, 32'd7);
    tick(); #1;
    checkOutput("single_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    checkOutput("single_rsp_id", {31'b0, bus.rsp_id}, '0);
    checkOutput("single_rsp_data", bus.rsp_data, 32'd12);

    // Contention straight after reset: port 0 first, then port 1
    tick(); rstN = 1'b0;
    tick(); rstN = 1'b1;
    tick();
    applyStimulus(0, OP_SUB, 32'd10, 32'd3);
    applyStimulus(1, OP_XOR, 32'hF0, 32'h0F);
    tick(); #1;
    checkOutput("cont_ready0", {31'b0, bus.req0_ready}, 32'd1);
    checkOutput("cont_ready1", {31'b0, bus.req1_ready}, '0);
    tick(); #1;
    checkOutput("cont_rsp1_id", {31'b0, bus.rsp_id}, '0);
    checkOutput("cont_rsp1_data", bus.rsp_data, 32'd7);
    checkOutput("cont_ready1_next", {31'b0, bus.req1_ready}, 32'd1);
    tick(); #1;
    checkOutput("cont_rsp2_valid", {31'b0, bus.rsp_valid}, 32'd1);
    checkOutput("cont_rsp2_id", {31'b0, bus.rsp_id}, 32'd1);
    checkOutput("cont_rsp2_data", bus.rsp_data, 32'hFF);

    // Back-pressure: slot stalls three cycles while port 1 waits
    tick();
    bus.rsp_ready = 1'b0;
    applyStimulus(0, OP_SUM, 32'd1, 32'd2);
    applyStimulus(1, OP_AND, 32'hFF00, 32'h0FF0);
    tick(); #1;
    checkOutput("bp_ready0", {31'b0, bus.req0_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      checkOutput("bp_stall_valid", {31'b0, bus.rsp_valid}, 32'd1);
      checkOutput("bp_stall_id", {31'b0, bus.rsp_id}, '0);
      checkOutput("bp_stall_data", bus.rsp_data, 32'd3);
      checkOutput("bp_stall_ready1", {31'b0, bus.req1_ready}, '0);
    end
    tick();
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready1", {31'b0, bus.req1_ready}, 32'd1);
    tick(); #1;
    checkOutput("bp_rsp_id", {31'b0, bus.rsp_id}, 32'd1);
    checkOutput("bp_rsp_data", bus.rsp_data, 32'h0F00);

    // Streaming: 8 ops per port, last served was port 1 so port 0 leads
    tick();
    gotIds.delete();
    gotCyc.delete();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, (i == 3) ? OP_BAD : OP_SUM, $urandom, $urandom);
      applyStimulus(1, (i % 2 == 0) ? OP_XOR : OP_SUB, $urandom, $urandom);
    end
    waited = 0;
    while (gotIds.size() < 16 && waited < 60) begin
      tick();
      waited++;
    end
    checkOutput("stream_count", gotIds.size(), 32'd16);
    if (gotIds.size() >= 16) begin
      checkOutput("stream_span", gotCyc[15] - gotCyc[0], 32'd15);
      for (int i = 0; i < 16; i++)
        checkOutput("stream_id_order", {31'b0, gotIds[i]}, i % 2);
    end

    // Randomised traffic with random consumer stalls
    for (int t = 0; t < 300; t++) begin
      tick();
      bus.rsp_ready = ($urandom % 4) != 0;
      if ($urandom % 3 == 0 && stimQ0.size() < 4)
        applyStimulus(0, 10'h001 << ($urandom % 6), $urandom, $urandom);
      if ($urandom % 3 == 0 && stimQ1.size() < 4)
        applyStimulus(1, 10'h001 << ($urandom % 6), $urandom, $urandom);
    end
    tick();
    bus.rsp_ready = 1'b1;
    waited = 0;
    while ((stimQ0.size() + stimQ1.size() + expQ0.size() + expQ1.size()) != 0 && waited < 100) begin
      tick();
      waited++;
    end
    checkOutput("random_drain", stimQ0.size() + stimQ1.size() + expQ0.size() + expQ1.size(), '0);

    // Reset while a response is held: dropped immediately, never delivered
    tick();
    bus.rsp_ready = 1'b0;
    applyStimulus(0, OP_OR, 32'h3, 32'hC);
    tick();
    tick(); #1;
    checkOutput("midrst_pre_valid", {31'b0, bus.rsp_valid}, 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("midrst_valid", {31'b0, bus.rsp_valid}, '0);
    checkOutput("midrst_ready0", {31'b0, bus.req0_ready}, '0);
    expQ0.delete();
    tick();
    rstN = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      checkOutput("midrst_no_rsp", {31'b0, bus.rsp_valid}, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
